// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter that shares one 4-digit seven-segment display between requesters.
// The winner's value is converted to BCD by a sequential double-dabble, then held for a minimum dwell.
module seg7_display_arbiter #(
  parameter  int NUM_REQ     = 2,
  parameter  int INPUT_WIDTH = 14,
  parameter  int HOLD_CYCLES = 1000,
  localparam int OW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_value,
  input  logic [NUM_REQ*4-1:0]           i_dp,
  output logic [NUM_REQ-1:0]             o_gnt,
  output logic [OW-1:0]                  o_owner,
  output logic [15:0]                    o_bcd,
  output logic [3:0]                     o_dp,
  output logic                           o_disp_valid,
  output logic                           o_ovf,
  output logic                           o_busy
);

  localparam int W  = INPUT_WIDTH;
  localparam int CW = $clog2(W);
  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   winner;
  logic            found;
  logic [W-1:0]    value_sr;
  logic [3:0]      dp_lat;
  logic            ovf_next;
  logic [15:0]     scratch;
  logic [15:0]     scratch_adj;
  logic [15:0]     scratch_shift;
  logic [CW-1:0]   shift_cnt;
  logic [DW-1:0]   dwell_cnt;
  logic            last_shift;
  logic [W-1:0]    val_sel;
  logic [W-1:0]    val_sat;
  logic            ovf_sat;

  // Round-robin search: first asserted request at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_req[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

  always_comb begin
    val_sel = i_value[int'(winner)*W +: W];
    ovf_sat = (32'(val_sel) > 32'd9999);
    val_sat = ovf_sat ? W'(9999) : val_sel;
  end

  // Double-dabble step: correct each digit that would overflow past 9, then shift in the next MSB.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < 4; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    scratch_shift = {scratch_adj[14:0], value_sr[W-1]};
  end

  assign last_shift = (shift_cnt == CW'(W - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = CONVERT;
      CONVERT: if (last_shift) state_next = SHOW;
      SHOW:    if (dwell_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gnt        <= '0;
      o_owner      <= '0;
      o_bcd        <= '0;
      o_dp         <= '0;
      o_disp_valid <= 1'b0;
      o_ovf        <= 1'b0;
      rr_ptr       <= '0;
      value_sr     <= '0;
      dp_lat       <= '0;
      ovf_next     <= 1'b0;
      scratch      <= '0;
      shift_cnt    <= '0;
      dwell_cnt    <= '0;
    end else begin
      o_gnt <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            o_gnt     <= NUM_REQ'(1) << winner;
            o_owner   <= winner;
            rr_ptr    <= (winner == OW'(NUM_REQ - 1)) ? '0 : winner + OW'(1);
            value_sr  <= val_sat;
            dp_lat    <= i_dp[int'(winner)*4 +: 4];
            ovf_next  <= ovf_sat;
            scratch   <= '0;
            shift_cnt <= '0;
          end
        end
        CONVERT: begin
          scratch   <= scratch_shift;
          value_sr  <= value_sr << 1;
          shift_cnt <= shift_cnt + CW'(1);
          // Display registers change only once the full conversion is available.
          if (last_shift) begin
            o_bcd        <= scratch_shift;
            o_dp         <= dp_lat;
            o_ovf        <= ovf_next;
            o_disp_valid <= 1'b1;
            dwell_cnt    <= DW'(HOLD_CYCLES - 1);
          end
        end
        SHOW: begin
          if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - DW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state == CONVERT) || (state == SHOW);

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed testbench for seg7_display_arbiter (NUM_REQ=2, INPUT_WIDTH=14, HOLD_CYCLES=8).
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_seg7_display_arbiter;

  localparam int N = 2;
  localparam int W = 14;
  localparam int H = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [N-1:0]  i_req;
  logic [N*W-1:0] i_value;
  logic [N*4-1:0] i_dp;
  logic [N-1:0]  o_gnt;
  logic [0:0]    o_owner;
  logic [15:0]   o_bcd;
  logic [3:0]    o_dp;
  logic          o_disp_valid;
  logic          o_ovf;
  logic          o_busy;

  int checks = 0;
  int errors = 0;

  seg7_display_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(W), .HOLD_CYCLES(H)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_value(i_value), .i_dp(i_dp),
    .o_gnt(o_gnt), .o_owner(o_owner), .o_bcd(o_bcd), .o_dp(o_dp),
    .o_disp_valid(o_disp_valid), .o_ovf(o_ovf), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic apply_reset();
    i_rst_n = 1'b0;
    i_req   = '0;
    i_value = '0;
    i_dp    = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  // Waits up to 'bound' edges for a grant; n = edges waited, ok = grant seen.
  task automatic wait_gnt(input int bound, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge i_clk);
      #1;
      if (o_gnt != '0) begin
        n  = i;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk);
      #1;
      checks++;
      if ({o_gnt, o_owner, o_bcd, o_dp, o_disp_valid, o_ovf, o_busy} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: gnt=%b owner=%0d bcd=%h dp=%b valid=%b ovf=%b busy=%b, required all 0",
                 i, o_gnt, o_owner, o_bcd, o_dp, o_disp_valid, o_ovf, o_busy);
      end
    end
  endtask

  task automatic test_single();
    int n; bit ok;
    apply_reset();
    i_value[0 +: W] = 14'd1234;
    i_dp[0 +: 4]    = 4'b0100;
    i_req           = 2'b01;
    wait_gnt(10, n, ok);
    checks++;
    if (!ok || o_gnt !== 2'b01 || o_owner !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: ok=%b gnt=%b owner=%0d, required gnt=01 owner=0", ok, o_gnt, o_owner);
    end
    i_req = 2'b00;
    @(posedge i_clk); #1;
    checks++;
    if (o_gnt !== 2'b00 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse: gnt=%b busy=%b, required gnt=00 busy=1", o_gnt, o_busy);
    end
    repeat (12) @(posedge i_clk);
    #1;
    checks++;
    if (o_disp_valid !== 1'b0 || o_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL single_early: valid=%b bcd=%h, required valid=0 bcd=0000", o_disp_valid, o_bcd);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_bcd !== 16'h1234 || o_dp !== 4'b0100 || o_disp_valid !== 1'b1 || o_owner !== 1'b0 || o_ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_result: bcd=%h dp=%b valid=%b owner=%0d ovf=%b, required 1234 0100 1 0 0",
               o_bcd, o_dp, o_disp_valid, o_owner, o_ovf);
    end
    repeat (H) @(posedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_bcd !== 16'h1234 || o_disp_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_persist: busy=%b bcd=%h valid=%b, required busy=0 bcd=1234 valid=1", o_busy, o_bcd, o_disp_valid);
    end
  endtask

  task automatic test_round_robin();
    int n; bit ok;
    logic [15:0] exp_bcd;
    apply_reset();
    i_value = {14'd9876, 14'd42};
    i_req   = 2'b11;
    wait_gnt(10, n, ok);
    for (int k = 0; k < 4; k++) begin
      exp_bcd = (k % 2 == 0) ? 16'h0042 : 16'h9876;
      checks++;
      if (!ok || o_owner !== 1'(k % 2) || o_gnt !== (2'b01 << (k % 2))) begin
        errors++;
        $display("FAIL rr_order grant %0d: ok=%b gnt=%b owner=%0d, required owner=%0d", k, ok, o_gnt, o_owner, k % 2);
      end
      if (k == 3) i_req = 2'b00;
      repeat (W) @(posedge i_clk);
      #1;
      checks++;
      if (o_bcd !== exp_bcd) begin
        errors++;
        $display("FAIL rr_value grant %0d: bcd=%h, required %h", k, o_bcd, exp_bcd);
      end
      if (k < 3) begin
        wait_gnt(40, n, ok);
        checks++;
        if (!ok || n != H + 1) begin
          errors++;
          $display("FAIL rr_spacing grant %0d: ok=%b edges after update=%0d, required %0d", k + 1, ok, n, H + 1);
        end
      end
    end
    repeat (H) @(posedge i_clk);
  endtask

  task automatic test_overflow();
    int n; bit ok;
    apply_reset();
    i_value[0 +: W] = 14'd12000;
    i_req           = 2'b01;
    wait_gnt(10, n, ok);
    repeat (W) @(posedge i_clk);
    #1;
    checks++;
    if (!ok || o_bcd !== 16'h9999 || o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sat: ok=%b bcd=%h ovf=%b, required bcd=9999 ovf=1", ok, o_bcd, o_ovf);
    end
    i_value[0 +: W] = 14'd0;
    wait_gnt(40, n, ok);
    checks++;
    if (!ok || o_gnt !== 2'b01) begin
      errors++;
      $display("FAIL ovf_regrant: ok=%b gnt=%b, required gnt=01", ok, o_gnt);
    end
    i_req = 2'b00;
    repeat (W - 1) @(posedge i_clk);
    #1;
    checks++;
    if (o_bcd !== 16'h9999 || o_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold: bcd=%h ovf=%b, required old bcd=9999 ovf=1", o_bcd, o_ovf);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_bcd !== 16'h0000 || o_ovf !== 1'b0 || o_disp_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_zero: bcd=%h ovf=%b valid=%b, required 0000 0 1", o_bcd, o_ovf, o_disp_valid);
    end
    repeat (H) @(posedge i_clk);
  endtask

  task automatic test_late_request();
    int n; bit ok;
    apply_reset();
    i_value = {14'd77, 14'd555};
    i_req   = 2'b01;
    wait_gnt(10, n, ok);
    i_req = 2'b00;
    repeat (3) @(posedge i_clk);
    #1 i_req = 2'b10;
    for (int e = 4; e <= 1 + W + H; e++) begin
      @(posedge i_clk);
      #1;
      if (e < 1 + W + H) begin
        checks++;
        if (o_gnt !== 2'b00) begin
          errors++;
          $display("FAIL late_no_grant edge %0d: gnt=%b, required 00", e, o_gnt);
        end
      end
      if (e == W - 1) begin
        checks++;
        if (o_bcd !== 16'h0000) begin
          errors++;
          $display("FAIL late_old_value: bcd=%h, required 0000", o_bcd);
        end
      end
      if (e == W) begin
        checks++;
        if (o_bcd !== 16'h0555) begin
          errors++;
          $display("FAIL late_new_value: bcd=%h, required 0555", o_bcd);
        end
      end
    end
    checks++;
    if (o_gnt !== 2'b10 || o_owner !== 1'b1) begin
      errors++;
      $display("FAIL late_grant: gnt=%b owner=%0d, required gnt=10 owner=1", o_gnt, o_owner);
    end
    i_req = 2'b00;
    repeat (W + H) @(posedge i_clk);
  endtask

  task automatic test_reset_midop();
    int n; bit ok;
    apply_reset();
    i_value = {14'd321, 14'd1234};
    i_req   = 2'b01;
    wait_gnt(10, n, ok);
    i_req = 2'b00;
    repeat (5) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_gnt, o_owner, o_bcd, o_dp, o_disp_valid, o_ovf, o_busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: gnt=%b owner=%0d bcd=%h dp=%b valid=%b ovf=%b busy=%b, required all 0",
               o_gnt, o_owner, o_bcd, o_dp, o_disp_valid, o_ovf, o_busy);
    end
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      checks++;
      if (o_gnt !== 2'b00 || o_busy !== 1'b0 || o_bcd !== 16'h0000) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d: gnt=%b busy=%b bcd=%h, required 00 0 0000", i, o_gnt, o_busy, o_bcd);
      end
    end
    i_req = 2'b10;
    wait_gnt(10, n, ok);
    checks++;
    if (!ok || o_gnt !== 2'b10 || o_owner !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant: ok=%b gnt=%b owner=%0d, required gnt=10 owner=1", ok, o_gnt, o_owner);
    end
    i_req = 2'b11;
    repeat (W) @(posedge i_clk);
    #1;
    checks++;
    if (o_bcd !== 16'h0321) begin
      errors++;
      $display("FAIL post_reset_value: bcd=%h, required 0321", o_bcd);
    end
    wait_gnt(40, n, ok);
    checks++;
    if (!ok || o_gnt !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_rr: ok=%b gnt=%b, required gnt=01", ok, o_gnt);
    end
    i_req = 2'b00;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req   = '0;
    i_value = '0;
    i_dp    = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_late_request();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
